ball_engine: RTL and testbench

BALL_ENGINE -- requirements
Module: ball_engine

---
 rtl/ball_engine.sv | 203 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball motion engine: serves the ball from the centre, moves it on each
// timing tick, bounces off the walls and paddles, detects misses and keeps score.
//
// state | meaning
// SERVE | ball held at the centre, serve counter runs on ticks while enabled
// PLAY  | ball moves on each enabled tick
// MISS  | single-cycle miss pulse, score already updated
module ball_engine #(
    parameter int HOR_PIXELS       = 1024,
    parameter int VER_PIXELS       = 768,
    parameter int BALL_SIZE        = 15,
    parameter int X_PAD_L          = 30,
    parameter int X_PAD_R          = 979,
    parameter int PAD_WIDTH        = 15,
    parameter int PAD_HEIGHT       = 145,
    parameter int VEL_INIT         = 2,
    parameter int VEL_MAX          = 6,
    parameter int HITS_PER_SPEEDUP = 4,
    parameter int SERVE_TICKS      = 60,
    parameter int SCORE_W          = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timing_tick,
    input  logic               game_en,
    input  logic [9:0]         y_pad_left,
    input  logic [9:0]         y_pad_right,
    output logic [10:0]        x_ball,
    output logic [10:0]        y_ball,
    output logic               miss_left,
    output logic               miss_right,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               ball_active
);

    localparam int SC_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam int HC_W = (HITS_PER_SPEEDUP > 1) ? $clog2(HITS_PER_SPEEDUP) : 1;

    localparam logic [11:0] X0      = 12'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] Y0      = 12'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] Y_MAX   = 12'(VER_PIXELS - BALL_SIZE);
    localparam logic [11:0] X_LIM_L = 12'(X_PAD_L + PAD_WIDTH);
    localparam logic [11:0] X_LIM_R = 12'(X_PAD_R - BALL_SIZE);
    localparam logic [11:0] X_PR    = 12'(X_PAD_R);
    localparam logic [11:0] HOR     = 12'(HOR_PIXELS);
    localparam logic [11:0] BS      = 12'(BALL_SIZE);
    localparam logic [11:0] PH      = 12'(PAD_HEIGHT);
    localparam logic [11:0] V0      = 12'(VEL_INIT);
    localparam logic [11:0] VMAX    = 12'(VEL_MAX);

    localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_TICKS - 1);
    localparam logic [HC_W-1:0]    HIT_LAST   = HC_W'(HITS_PER_SPEEDUP - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [1:0] {SERVE, PLAY, MISS} state_t;

    state_t          state;
    logic            dir_x;        // 1 = moving right
    logic            dir_y;        // 1 = moving down
    logic [11:0]     vx;
    logic [SC_W-1:0] serve_cnt;
    logic [HC_W-1:0] hit_cnt;

    logic [11:0] x_w, y_w, pl_w, pr_w;
    logic        ovl_l, ovl_r;
    logic [10:0] x_nxt, y_nxt;
    logic        dir_x_nxt, dir_y_nxt;
    logic        hit, miss_l_det, miss_r_det;

    // Next-position logic for one PLAY tick; all arithmetic in 12 bits so
    // the edge sums never wrap.
    always_comb begin
        x_w  = {1'b0, x_ball};
        y_w  = {1'b0, y_ball};
        pl_w = {2'b00, y_pad_left};
        pr_w = {2'b00, y_pad_right};

        ovl_l = (y_w + BS >= pl_w) && (y_w <= pl_w + PH);
        ovl_r = (y_w + BS >= pr_w) && (y_w <= pr_w + PH);

        y_nxt     = y_ball;
        dir_y_nxt = dir_y;
        if (dir_y) begin
            if (y_w + V0 >= Y_MAX) begin
                y_nxt     = Y_MAX[10:0];
                dir_y_nxt = 1'b0;
            end else begin
                y_nxt = 11'(y_w + V0);
            end
        end else begin
            if (y_w <= V0) begin
                y_nxt     = '0;
                dir_y_nxt = 1'b1;
            end else begin
                y_nxt = 11'(y_w - V0);
            end
        end

        x_nxt      = x_ball;
        dir_x_nxt  = dir_x;
        hit        = 1'b0;
        miss_l_det = 1'b0;
        miss_r_det = 1'b0;
        if (!dir_x) begin
            // x - vx <= limit, rearranged to avoid underflow near the wall
            if ((x_w <= X_LIM_L + vx) && ovl_l) begin
                x_nxt     = X_LIM_L[10:0];
                dir_x_nxt = 1'b1;
                hit       = 1'b1;
            end else if (x_w <= vx) begin
                miss_l_det = 1'b1;
            end else begin
                x_nxt = 11'(x_w - vx);
            end
        end else begin
            if ((x_w + BS + vx >= X_PR) && ovl_r) begin
                x_nxt     = X_LIM_R[10:0];
                dir_x_nxt = 1'b0;
                hit       = 1'b1;
            end else if (x_w + BS + vx >= HOR) begin
                miss_r_det = 1'b1;
            end else begin
                x_nxt = 11'(x_w + vx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SERVE;
            x_ball      <= X0[10:0];
            y_ball      <= Y0[10:0];
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
            vx          <= V0;
            serve_cnt   <= '0;
            hit_cnt     <= '0;
            score_left  <= '0;
            score_right <= '0;
            miss_left   <= 1'b0;
            miss_right  <= 1'b0;
            ball_active <= 1'b0;
        end else begin
            miss_left  <= 1'b0;
            miss_right <= 1'b0;
            case (state)
                SERVE: begin
                    if (timing_tick && game_en) begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt   <= '0;
                            state       <= PLAY;
                            ball_active <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + SC_W'(1);
                        end
                    end
                end
                PLAY: begin
                    if (timing_tick && game_en) begin
                        x_ball <= x_nxt;
                        y_ball <= y_nxt;
                        dir_x  <= dir_x_nxt;
                        dir_y  <= dir_y_nxt;
                        if (hit) begin
                            if (hit_cnt == HIT_LAST) begin
                                hit_cnt <= '0;
                                vx      <= (vx < VMAX) ? vx + 12'd1 : VMAX;
                            end else begin
                                hit_cnt <= hit_cnt + HC_W'(1);
                            end
                        end
                        if (miss_l_det) begin
                            state       <= MISS;
                            ball_active <= 1'b0;
                            miss_left   <= 1'b1;
                            if (score_right != SCORE_MAX)
                                score_right <= score_right + SCORE_W'(1);
                        end
                        if (miss_r_det) begin
                            state       <= MISS;
                            ball_active <= 1'b0;
                            miss_right  <= 1'b1;
                            if (score_left != SCORE_MAX)
                                score_left <= score_left + SCORE_W'(1);
                        end
                    end
                end
                MISS: begin
                    // Serve toward the side that just missed' opponent; y keeps its direction.
                    state   <= SERVE;
                    x_ball  <= X0[10:0];
                    y_ball  <= Y0[10:0];
                    vx      <= V0;
                    hit_cnt <= '0;
                    dir_x   <= miss_left;
                end
                default: state <= SERVE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: table-driven reset/serve vectors, a
// cycle-level reference model feeding a scoreboard, and directed corner cases.
module tb_ball_engine;

    localparam int X0 = 504;
    localparam int Y0 = 376;
    localparam int TRACK = 0;
    localparam int AWAY  = 1;

    logic        clk = 1'b0;
    logic        rst, timing_tick, game_en;
    logic [9:0]  y_pad_left, y_pad_right;
    logic [10:0] x_ball, y_ball;
    logic        miss_left, miss_right;
    logic [3:0]  score_left, score_right;
    logic        ball_active;

    ball_engine dut (
        .clk(clk), .rst(rst), .timing_tick(timing_tick), .game_en(game_en),
        .y_pad_left(y_pad_left), .y_pad_right(y_pad_right),
        .x_ball(x_ball), .y_ball(y_ball),
        .miss_left(miss_left), .miss_right(miss_right),
        .score_left(score_left), .score_right(score_right),
        .ball_active(ball_active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        ml;
        logic        mr;
        logic [3:0]  sl;
        logic [3:0]  sr;
        logic        act;
    } outs_t;

    typedef struct {
        logic  r;
        logic  t;
        logic  e;
        int    pl;
        int    pr;
        outs_t want;
    } vec_t;

    outs_t exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    // reference model state (0 serve, 1 play, 2 miss)
    int ms, mx, my, mdx, mdy, mvx, mcnt, mhits, msl, msr, mml, mmr, mact;
    int hit_events = 0;

    task automatic model_step(input logic r, input logic t, input logic e,
                              input int pl, input int pr);
        int nx, ny, ndx, ndy;
        bit hit, lm, rm, ovl, ovr;
        if (r) begin
            ms = 0; mx = X0; my = Y0; mdx = 0; mdy = 0; mvx = 2;
            mcnt = 0; mhits = 0; msl = 0; msr = 0; mml = 0; mmr = 0; mact = 0;
            return;
        end
        if (ms == 2) begin
            ms = 0; mx = X0; my = Y0; mvx = 2; mhits = 0;
            mdx = mml; mml = 0; mmr = 0;
            return;
        end
        if (!(t && e)) return;
        if (ms == 0) begin
            if (mcnt == 59) begin mcnt = 0; ms = 1; mact = 1; end
            else mcnt++;
            return;
        end
        ovl = (my + 15 >= pl) && (my <= pl + 145);
        ovr = (my + 15 >= pr) && (my <= pr + 145);
        if (mdy != 0) begin
            ny = my + 2; ndy = 1;
            if (ny >= 753) begin ny = 753; ndy = 0; end
        end else begin
            ny = my - 2; ndy = 0;
            if (my <= 2) begin ny = 0; ndy = 1; end
        end
        hit = 0; lm = 0; rm = 0; nx = mx; ndx = mdx;
        if (mdx == 0) begin
            if (mx - mvx <= 45 && ovl) begin nx = 45; ndx = 1; hit = 1; end
            else if (mx <= mvx) lm = 1;
            else nx = mx - mvx;
        end else begin
            if (mx + 15 + mvx >= 979 && ovr) begin nx = 964; ndx = 0; hit = 1; end
            else if (mx + 15 + mvx >= 1024) rm = 1;
            else nx = mx + mvx;
        end
        mx = nx; my = ny; mdx = ndx; mdy = ndy;
        if (hit) begin
            hit_events++;
            mhits++;
            if (mhits == 4) begin mhits = 0; if (mvx < 6) mvx++; end
        end
        if (lm) begin ms = 2; mml = 1; mact = 0; if (msr < 15) msr++; end
        if (rm) begin ms = 2; mmr = 1; mact = 0; if (msl < 15) msl++; end
    endtask

    function automatic outs_t model_outs();
        outs_t o;
        o.x = 11'(mx); o.y = 11'(my); o.ml = mml[0]; o.mr = mmr[0];
        o.sl = 4'(msl); o.sr = 4'(msr); o.act = mact[0];
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.x = x_ball; o.y = y_ball; o.ml = miss_left; o.mr = miss_right;
        o.sl = score_left; o.sr = score_right; o.act = ball_active;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t a, input outs_t w);
        n_vec++;
        if (a !== w) begin
            n_miss++;
            $display("FAIL %s: got x=%0d y=%0d ml=%0b mr=%0b sl=%0d sr=%0d act=%0b, expected x=%0d y=%0d ml=%0b mr=%0b sl=%0d sr=%0d act=%0b",
                     name, a.x, a.y, a.ml, a.mr, a.sl, a.sr, a.act,
                     w.x, w.y, w.ml, w.mr, w.sl, w.sr, w.act);
        end
    endtask

    task automatic check_int(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic bound_chk(input string name, input bit reached);
        if (!reached) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: cycle budget expired, got not reached, expected reached", name);
        end
    endtask

    // One clock: drive at negedge, push expectation, compare 1 time unit after posedge.
    task automatic cycle(input logic r, input logic t, input logic e, input int pl,
                         input int pr, input bit use_c, input outs_t cexp,
                         input string name);
        outs_t w;
        @(negedge clk);
        rst = r; timing_tick = t; game_en = e;
        y_pad_left = 10'(pl); y_pad_right = 10'(pr);
        model_step(r, t, e, pl, pr);
        exp_q.push_back(use_c ? cexp : model_outs());
        @(posedge clk);
        #1;
        w = exp_q.pop_front();
        check_outs(name, dut_outs(), w);
    endtask

    function automatic int pad_for(input int mode);
        int p;
        if (mode == TRACK) begin
            p = my - 65;
            if (p < 0) p = 0;
        end else begin
            p = (my < 400) ? 600 : 0;
        end
        return p;
    endfunction

    task automatic play_tick(input int mode);
        int p;
        p = pad_for(mode);
        cycle(1'b0, 1'b1, 1'b1, p, p, 1'b0, '0, "model");
    endtask

    task automatic check_step(input string name, input int want);
        int x0, d;
        for (int i = 0; i < 600 && !(mx >= 200 && mx <= 700); i++) play_tick(TRACK);
        bound_chk({name, "_reach"}, mx >= 200 && mx <= 700);
        x0 = int'(x_ball);
        play_tick(TRACK);
        d = int'(x_ball) - x0;
        if (d < 0) d = -d;
        check_int(name, d, want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[5];
        outs_t rst_o, c;
        int    psl;
        bit    done;

        rst_o.x = 11'd504; rst_o.y = 11'd376; rst_o.ml = 1'b0; rst_o.mr = 1'b0;
        rst_o.sl = 4'd0; rst_o.sr = 4'd0; rst_o.act = 1'b0;
        tbl[0] = '{r: 1'b1, t: 1'b0, e: 1'b0, pl: 0,   pr: 0,   want: rst_o};
        tbl[1] = '{r: 1'b1, t: 1'b1, e: 1'b1, pl: 300, pr: 300, want: rst_o};
        tbl[2] = '{r: 1'b0, t: 1'b1, e: 1'b0, pl: 300, pr: 300, want: rst_o};
        tbl[3] = '{r: 1'b0, t: 1'b0, e: 1'b1, pl: 300, pr: 300, want: rst_o};
        tbl[4] = '{r: 1'b0, t: 1'b1, e: 1'b1, pl: 300, pr: 300, want: rst_o};

        rst = 1'b1; timing_tick = 1'b0; game_en = 1'b0;
        y_pad_left = '0; y_pad_right = '0;

        for (int i = 0; i < 5; i++)
            cycle(tbl[i].r, tbl[i].t, tbl[i].e, tbl[i].pl, tbl[i].pr, 1'b1,
                  tbl[i].want, $sformatf("table[%0d]", i));

        // ticks 2..59 with idle cycles in between; ball must stay parked
        for (int i = 0; i < 58; i++) begin
            play_tick(TRACK);
            cycle(1'b0, 1'b0, 1'b1, 300, 300, 1'b0, '0, "serve_idle");
        end
        check_int("serve_59_inactive", ball_active, 0);
        c = rst_o; c.act = 1'b1;
        cycle(1'b0, 1'b1, 1'b1, 300, 300, 1'b1, c, "serve_60th_tick");
        c.x = 11'd502; c.y = 11'd374;
        cycle(1'b0, 1'b1, 1'b1, 300, 300, 1'b1, c, "first_play_tick");

        // left paddle bounce
        for (int i = 0; i < 400 && !(ms == 1 && mdx == 0 && mx == 46); i++) play_tick(TRACK);
        bound_chk("reach_x46", ms == 1 && mdx == 0 && mx == 46);
        play_tick(TRACK);
        check_int("hit_left_x", x_ball, 45);
        play_tick(TRACK);
        check_int("after_hit_x", x_ball, 47);

        // floor and ceiling clamps
        for (int i = 0; i < 1000 && !(my == 752 && mdy == 1); i++) play_tick(TRACK);
        bound_chk("reach_y752", my == 752 && mdy == 1);
        play_tick(TRACK);
        check_int("floor_clamp_y", y_ball, 753);
        play_tick(TRACK);
        check_int("floor_bounce_y", y_ball, 751);
        for (int i = 0; i < 1000 && !(my == 1 && mdy == 0); i++) play_tick(TRACK);
        bound_chk("reach_y1", my == 1 && mdy == 0);
        play_tick(TRACK);
        check_int("ceil_clamp_y", y_ball, 0);
        play_tick(TRACK);
        check_int("ceil_bounce_y", y_ball, 2);

        // speed-up ladder
        for (int i = 0; i < 6000 && hit_events < 4; i++) play_tick(TRACK);
        bound_chk("reach_4_hits", hit_events >= 4);
        check_step("vx_after_4_hits", 3);
        for (int i = 0; i < 12000 && hit_events < 16; i++) play_tick(TRACK);
        bound_chk("reach_16_hits", hit_events >= 16);
        check_step("vx_after_16_hits", 6);
        for (int i = 0; i < 6000 && hit_events < 20; i++) play_tick(TRACK);
        bound_chk("reach_20_hits", hit_events >= 20);
        check_step("vx_after_20_hits", 6);

        // left miss at full speed
        for (int i = 0; i < 1000 && !(mdx == 0 && mx >= 200 && mx <= 900); i++) play_tick(TRACK);
        bound_chk("reach_leftward", mdx == 0 && mx >= 200 && mx <= 900);
        for (int i = 0; i < 500 && ms != 2; i++) play_tick(AWAY);
        bound_chk("reach_miss_left", ms == 2);
        check_int("miss_left_pulse", miss_left, 1);
        check_int("score_right_1", score_right, 1);
        c = rst_o; c.sr = 4'd1;
        cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, c, "miss_to_serve");
        for (int i = 0; i < 60; i++) play_tick(AWAY);
        check_int("reserve_active", ball_active, 1);
        play_tick(AWAY);
        check_int("reserve_first_x", x_ball, 506);

        // rally of misses with gated ticks and enable until score_left saturates
        done = 1'b0;
        for (int i = 0; i < 40000 && !done; i++) begin
            int p;
            p   = pad_for(AWAY);
            psl = msl;
            cycle(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) != 0),
                  p, p, 1'b0, '0, "rally");
            if (ms == 2 && mmr == 1 && psl == 15) done = 1'b1;
        end
        bound_chk("reach_saturation", done);
        check_int("score_left_sat", score_left, 15);
        check_int("miss_right_pulse", miss_right, 1);

        // reset taking priority over MISS
        cycle(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, '0, "leave_miss");
        for (int i = 0; i < 2000 && ms != 2; i++) play_tick(AWAY);
        bound_chk("reach_miss_again", ms == 2);
        cycle(1'b1, 1'b0, 1'b1, 0, 0, 1'b1, rst_o, "rst_in_miss");
        cycle(1'b0, 1'b1, 1'b1, 0, 0, 1'b0, '0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
